// File: rtl/alu_slice_sequencer.sv
// Sequences one combinational 4-bit ALU slice over a W-bit word, one nibble per cycle.
// Latency: out_valid rises NIBBLES cycles after accept; in_ready only in IDLE, result held until out_ready.
module alu_slice_sequencer #(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_f,
    input  logic         in_com,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_d,
    output logic         out_cout,
    output logic         out_zero,
    output logic         out_equ,
    output logic [3:0]   slice_a,
    output logic [3:0]   slice_b,
    output logic [2:0]   slice_f,
    output logic         slice_com,
    output logic         slice_ci_right,
    output logic         slice_ci_left,
    input  logic [3:0]   slice_d,
    input  logic         slice_co_left,
    input  logic         slice_co_right,
    input  logic         slice_equ
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0]    F_ADD = 3'd0;
    localparam logic [2:0]    F_SHR = 3'd6;
    localparam logic [2:0]    F_SHL = 3'd7;
    localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q, res_q, res_nxt;
    logic [2:0]    f_q;
    logic          com_q, c_q, c_nxt, equ_q, equ_nxt;
    logic [CW-1:0] cnt, idx;
    logic          last;
    logic          carry_fn;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == LAST);
    assign carry_fn  = (f_q == F_ADD) || (f_q == F_SHL) || (f_q == F_SHR);

    always_comb begin
        state_nxt      = state;
        idx            = cnt;
        slice_a        = 4'd0;
        slice_b        = 4'd0;
        slice_f        = 3'd0;
        slice_com      = 1'b0;
        slice_ci_right = 1'b0;
        slice_ci_left  = 1'b0;
        res_nxt        = res_q;
        c_nxt          = c_q;
        equ_nxt        = equ_q;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN: begin
                // right shifts walk MSB nibble first so the shift-in bit enters at the top
                idx       = (f_q == F_SHR) ? (LAST - cnt) : cnt;
                slice_a   = a_q[{idx, 2'b00} +: 4];
                slice_b   = b_q[{idx, 2'b00} +: 4];
                slice_f   = f_q;
                slice_com = com_q;
                case (f_q)
                    F_ADD, F_SHL: begin
                        slice_ci_right = c_q;
                        c_nxt          = slice_co_left;
                    end
                    F_SHR: begin
                        slice_ci_left = c_q;
                        c_nxt         = slice_co_right;
                    end
                    default: ;
                endcase
                res_nxt[{idx, 2'b00} +: 4] = slice_d;
                equ_nxt = equ_q & slice_equ;
                if (last) state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= 3'd0;
            com_q    <= 1'b0;
            c_q      <= 1'b0;
            cnt      <= '0;
            equ_q    <= 1'b0;
            res_q    <= '0;
            out_d    <= '0;
            out_cout <= 1'b0;
            out_zero <= 1'b0;
            out_equ  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= in_a;
                    b_q   <= in_b;
                    f_q   <= in_f;
                    com_q <= in_com;
                    c_q   <= in_cin;
                    cnt   <= '0;
                    equ_q <= 1'b1;
                    res_q <= '0;
                end
                RUN: begin
                    res_q <= res_nxt;
                    c_q   <= c_nxt;
                    equ_q <= equ_nxt;
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        out_d    <= res_nxt;
                        out_cout <= carry_fn & c_nxt;
                        out_zero <= (res_nxt == '0);
                        out_equ  <= equ_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: behavioural 4-bit slice plus a word-level reference model.
module tb_alu_slice_sequencer;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_f;
    logic         in_com, in_cin;
    logic         out_valid, out_ready;
    logic [W-1:0] out_d;
    logic         out_cout, out_zero, out_equ;
    logic [3:0]   slice_a, slice_b, slice_d;
    logic [2:0]   slice_f;
    logic         slice_com, slice_ci_right, slice_ci_left;
    logic         slice_co_left, slice_co_right, slice_equ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_slice_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_com(in_com), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_cout(out_cout), .out_zero(out_zero), .out_equ(out_equ),
        .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f), .slice_com(slice_com),
        .slice_ci_right(slice_ci_right), .slice_ci_left(slice_ci_left),
        .slice_d(slice_d), .slice_co_left(slice_co_left), .slice_co_right(slice_co_right),
        .slice_equ(slice_equ)
    );

    // Combinational 4-bit ALU slice
    always_comb begin
        logic [4:0] sum;
        logic [3:0] r;
        sum            = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_ci_right};
        r              = 4'd0;
        slice_co_left  = 1'b0;
        slice_co_right = 1'b0;
        case (slice_f)
            3'd0: begin r = sum[3:0]; slice_co_left = sum[4]; end
            3'd1: r = slice_a & slice_b;
            3'd2: r = slice_a | slice_b;
            3'd3: r = slice_a ^ slice_b;
            3'd4: r = slice_a;
            3'd5: r = slice_b;
            3'd6: begin r = {slice_ci_left, slice_a[3:1]}; slice_co_right = slice_a[0]; end
            default: begin r = {slice_a[2:0], slice_ci_right}; slice_co_left = slice_a[3]; end
        endcase
        slice_d   = slice_com ? ~r : r;
        slice_equ = (slice_a == slice_b);
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         cout;
        logic         zero;
        logic         equ;
    } res_t;

    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] f, input logic com, input logic cin);
        res_t         r;
        logic [W:0]   s;
        logic [W-1:0] v;
        r.cout = 1'b0;
        case (f)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + {16'd0, cin}; v = s[W-1:0]; r.cout = s[W]; end
            3'd1: v = a & b;
            3'd2: v = a | b;
            3'd3: v = a ^ b;
            3'd4: v = a;
            3'd5: v = b;
            3'd6: begin v = (a >> 1) | ({15'd0, cin} << (W - 1)); r.cout = a[0]; end
            default: begin v = (a << 1) | {15'd0, cin}; r.cout = a[W-1]; end
        endcase
        r.d    = com ? ~v : v;
        r.zero = (r.d == '0);
        r.equ  = (a == b);
        return r;
    endfunction

    // Runs one operation from the post-edge phase; scrambles in_* after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                          input logic com, input logic cin, input int stall,
                          output res_t got, output int lat, output logic [3:0] sa [N]);
        for (int k = 0; k < N; k++) sa[k] = 4'hx;
        in_a = a; in_b = b; in_f = f; in_com = com; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_f = 3'($urandom);
        in_com = 1'($urandom); in_cin = 1'($urandom);
        sa[0] = slice_a;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (lat < N) sa[lat] = slice_a;
        end
        got = '{d: out_d, cout: out_cout, zero: out_zero, equ: out_equ};
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_f = 3'd0; in_com = 1'b0; in_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_d, out_cout, out_zero, out_equ} !== {1'b1, 1'b0, 16'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b d=%h c=%b z=%b e=%b, need 1 0 0000 0 0 0",
                     in_ready, out_valid, out_d, out_cout, out_zero, out_equ);
        end
        checks++;
        if ({slice_a, slice_b, slice_f, slice_com, slice_ci_right, slice_ci_left} !== 17'd0) begin
            errors++;
            $display("FAIL reset_slice: a=%h b=%h f=%h com=%b cir=%b cil=%b, need all 0",
                     slice_a, slice_b, slice_f, slice_com, slice_ci_right, slice_ci_left);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [W-1:0] va [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8001, 16'h8001, 16'hF0F0};
        logic [W-1:0] vb [6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFF00};
        logic [2:0]   vf [6] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd6, 3'd1};
        logic         vc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        res_t         ex [6] = '{'{16'h0100, 1'b0, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b1, 1'b0},
                                 '{16'h8000, 1'b0, 1'b0, 1'b0}, '{16'h0003, 1'b1, 1'b0, 1'b0},
                                 '{16'h4000, 1'b1, 1'b0, 1'b0}, '{16'hF000, 1'b0, 1'b0, 1'b0}};
        logic [3:0]   shr_order [N] = '{4'h8, 4'h0, 4'h0, 4'h1};
        res_t got;
        int   lat;
        logic [3:0] sa [N];
        for (int t = 0; t < 6; t++) begin
            run_op(va[t], vb[t], vf[t], 1'b0, vc[t], 0, got, lat, sa);
            checks++;
            if (got !== ex[t] || got !== ref_op(va[t], vb[t], vf[t], 1'b0, vc[t])) begin
                errors++;
                $display("FAIL directed_%0d: d=%h c=%b z=%b e=%b, need d=%h c=%b z=%b e=%b", t,
                         got.d, got.cout, got.zero, got.equ, ex[t].d, ex[t].cout, ex[t].zero, ex[t].equ);
            end
            checks++;
            if (lat !== N) begin
                errors++;
                $display("FAIL latency_%0d: %0d cycles, need %0d", t, lat, N);
            end
            if (vf[t] == 3'd6) begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (sa[k] !== shr_order[k]) begin
                        errors++;
                        $display("FAIL shr_order_%0d: slice_a=%h, need %h", k, sa[k], shr_order[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_hold;
        res_t got, ex;
        ex = ref_op(16'h1234, 16'h1234, 3'd3, 1'b1, 1'b0);
        in_a = 16'h1234; in_b = 16'h1234; in_f = 3'd3; in_com = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 50 && !out_valid; k++) begin @(posedge clk); #1; end
        got = '{d: out_d, cout: out_cout, zero: out_zero, equ: out_equ};
        checks++;
        if (got !== ex || got.d !== 16'hFFFF || got.equ !== 1'b1) begin
            errors++;
            $display("FAIL hold_result: d=%h c=%b z=%b e=%b, need d=FFFF c=0 z=0 e=1",
                     got.d, got.cout, got.zero, got.equ);
        end
        in_a = 16'h0001; in_b = 16'h0002; in_f = 3'd0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_d === got.d && out_equ === got.equ
                  && out_zero === got.zero && out_cout === got.cout)) begin
                errors++;
                $display("FAIL hold_stall_%0d: valid=%b ready=%b d=%h, need 1 0 %h",
                         k, out_valid, in_ready, out_d, got.d);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        res_t got;
        int   lat;
        logic [3:0] sa [N];
        bit   seen;
        in_a = 16'h1111; in_b = 16'h2222; in_f = 3'd0; in_com = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || slice_a !== 4'd0 || slice_b !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b valid=%b sa=%h sb=%h, need 1 0 0 0",
                     in_ready, out_valid, slice_a, slice_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_discard: out_valid seen=%b ready=%b, need 0 1", seen, in_ready);
        end
        run_op(16'hF0F0, 16'hFF00, 3'd1, 1'b0, 1'b0, 0, got, lat, sa);
        checks++;
        if (got.d !== 16'hF000 || got.zero !== 1'b0 || got.cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_and: d=%h z=%b c=%b, need F000 0 0", got.d, got.zero, got.cout);
        end
    endtask

    task automatic test_random;
        res_t got, ex;
        int   lat;
        logic [3:0] sa [N];
        logic [W-1:0] a, b;
        logic [2:0] f;
        logic com, cin;
        for (int t = 0; t < 60; t++) begin
            a = W'($urandom); f = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            if ($urandom_range(0, 7) == 0) b = W'(~a) + 16'd1;
            ex = ref_op(a, b, f, com, cin);
            run_op(a, b, f, com, cin, $urandom_range(0, 2), got, lat, sa);
            checks++;
            if (got !== ex || lat !== N) begin
                errors++;
                $display("FAIL random_%0d: f=%0d a=%h b=%h com=%b cin=%b got d=%h c=%b z=%b e=%b lat=%0d, need d=%h c=%b z=%b e=%b lat=%0d",
                         t, f, a, b, com, cin, got.d, got.cout, got.zero, got.equ, lat,
                         ex.d, ex.cout, ex.zero, ex.equ, N);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc [$];
        in_a = 16'h0003; in_b = 16'h0004; in_f = 3'd0; in_com = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (N + 3) begin @(posedge clk); #1; end
        checks++;
        if (acc.size() < 4) begin
            errors++;
            $display("FAIL b2b_count: %0d accepts, need at least 4", acc.size());
        end else begin
            for (int k = 1; k < acc.size(); k++) begin
                checks++;
                if (acc[k] - acc[k-1] !== N + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: %0d cycles, need %0d", k, acc[k] - acc[k-1], N + 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
